io_uart_arbiter: RTL and testbench
==================================

Name: io_uart_arbiter

Overview:
Multi-port IO write arbiter for the UART console. It replaces the current OR of per-hart UART strobes, which loses a character whenever two harts write in the same cycle. Each of NPORTS IO ports gets its own TX FIFO, and the FIFOs drain round-robin into the single corescore_emitter_uart valid/ready interface. The block also owns per-port status readback and a drain-before-halt signal for the bench.

Parameters:
NPORTS, 2, number of IO master ports (one per hart/issue slot); 1..8
DEPTH, 16, per-port FIFO entries; power of two, 2..128
CW, $clog2(DEPTH)+1, FIFO occupancy counter width (derived; not overridable)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
io_wr  input  NPORTS  per-port IO write strobe, one cycle per access
io_addr  input  NPORTS*32  per-port IO byte address; port p at [32p+31:32p]
io_wdata  input  NPORTS*32  per-port IO write data
io_rdata  output  NPORTS*32  per-port IO read data, combinational from io_addr and state
uart_data  output  8  byte presented to UART
uart_valid  output  1  uart_data valid
uart_ready  input  1  UART ready; transfer when uart_valid & uart_ready at posedge
ovf  output  NPORTS  per-port sticky overflow flag
halt  output  1  all output drained after a halt request

Behaviour:
- Reset: one clock; resetn asynchronous, active-low. All FIFOs empty, counters 0, ovf=0, uart_valid=0, uart_data=0, halt=0, halt_pend=0, rr pointer=NPORTS-1 so port 0 wins first. Reset mid-transfer drops queued bytes and deasserts uart_valid immediately (async).
- Decode: wordaddr = io_addr[15:2].
  - bit1 = UART data.
  - bit2 = UART status.
  - bit3 = halt.
  - Multiple bits set → each decoded function acts.
- Data write (io_wr & wordaddr[1]): push io_wdata[7:0] into port FIFO.
  - Fullness is sampled before the edge. A write to a full FIFO is dropped and sets ovf[p], even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full FIFO: both occur, count unchanged.
- Status write (io_wr & wordaddr[2]): clears ovf[p]. A same-cycle new overflow wins; ovf stays 1.
- Halt write (io_wr & wordaddr[3]) from any port sets sticky halt_pend.
- halt is registered. It asserts the cycle after: halt_pend & all FIFOs empty & !uart_valid. It then holds until reset.
- Status read (wordaddr[2]) returns {21'b0, ovf[p], full[p], 1'b0, count[p] zero-extended to 8 bits}.
  - Bit 9 = full keeps existing poll loops working.
  - Any other address reads 0.
- Output stage: one register (uart_data, uart_valid).
  - Loads when empty or being consumed (uart_valid & uart_ready) and some FIFO is non-empty.
  - Grant goes to the first non-empty port after rr, wrapping; rr then updates to the granted port and the granted FIFO pops on the same edge.
  - Back-to-back transfers are supported with no bubble.
  - uart_data stays stable while uart_valid & !uart_ready.
- Latency: write at edge t into an empty system → uart_valid high after edge t+1.
- Ordering: per-port FIFO order is preserved. Interleaving across ports is strictly round-robin per byte.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; full = (count==DEPTH).

Decomposition:
- Package io_pkg holds:
  - IO word-address bit positions: IO_UART_DAT=1, IO_UART_STAT=2, IO_HALT=3.
  - Status bit positions: ST_FULL=9, ST_OVF=10.
- Sub-module io_txfifo: single-clock synchronous FIFO, parameter DEPTH.
  - Ports: clk, resetn, push, din[7:0], pop, dout[7:0], count[CW-1:0], full, empty.
  - Instantiated NPORTS times in a generate loop.
- Top level holds decode, round-robin arbiter, output register and halt logic.

Test Plan:
- Simultaneous write, NPORTS=2, uart_ready=1: port0 writes 0x41 and port1 writes 0x42 at cycle 0. Required: uart_data 0x41 then 0x42 on consecutive valid cycles; ovf=0.
- Fairness: port0 queues "AAAA" and port1 queues "BB" while uart_ready=0, then ready goes high. Required output order: A,B,A,B,A,A.
- Backpressure: hold uart_ready=0 for 20 cycles with one byte pending. Required: uart_valid stays 1, uart_data is unchanged, and count is unchanged.
- Overflow: uart_ready=0, port1 writes DEPTH+1 bytes. Required:
  - ovf[1]=1 and status read on port1 = 0x0000_0610 (DEPTH=16).
  - A status write clears ovf[1].
  - Drain yields exactly the first 16 bytes.
- Halt drain: port0 queues 3 bytes, then writes the halt address. Required: halt=0 until the third byte transfers, then halt=1 one cycle after uart_valid drops.
- Async reset: assert resetn=0 mid-stream between clock edges. Required: uart_valid=0 and halt=0 immediately, all counts 0, and rr resets so port 0 is granted first afterwards.

Source files
------------

// File: rtl/io_pkg.sv
// Shared IO decode and status-word bit positions for the UART console arbiter.
// Word-address bits are decoded independently, so one access may hit several.
package io_pkg;

    localparam int unsigned IO_UART_DAT  = 1;
    localparam int unsigned IO_UART_STAT = 2;
    localparam int unsigned IO_HALT      = 3;

    localparam int unsigned ST_FULL = 9;
    localparam int unsigned ST_OVF  = 10;

endpackage

// File: rtl/io_txfifo.sv
// Per-port byte FIFO feeding the round-robin UART arbiter.
// Single clock, first-word-fall-through read port, occupancy counter 0..DEPTH.
module io_txfifo #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/io_uart_arbiter.sv
// Per-hart UART TX FIFOs drained round-robin into one valid/ready byte stream,
// with per-port status readback, sticky overflow flags and drain-before-halt.
module io_uart_arbiter
    import io_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NPORTS-1:0]    io_wr,
    input  logic [NPORTS*32-1:0] io_addr,
    input  logic [NPORTS*32-1:0] io_wdata,
    output logic [NPORTS*32-1:0] io_rdata,
    output logic [7:0]           uart_data,
    output logic                 uart_valid,
    input  logic                 uart_ready,
    output logic [NPORTS-1:0]    ovf,
    output logic                 halt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0] dat_wr;
    logic [NPORTS-1:0] stat_wr;
    logic [NPORTS-1:0] halt_wr;
    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] full;
    logic [NPORTS-1:0] empty;
    logic [7:0]        dout  [NPORTS];
    logic [CW-1:0]     count [NPORTS];

    logic [PW-1:0] rr;
    logic [PW-1:0] gnt;
    logic          any_ne;
    logic          load;
    logic          halt_pend;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [13:0] wa;

        assign wa         = io_addr[32*p+15 : 32*p+2];
        assign dat_wr[p]  = io_wr[p] & wa[IO_UART_DAT];
        assign stat_wr[p] = io_wr[p] & wa[IO_UART_STAT];
        assign halt_wr[p] = io_wr[p] & wa[IO_HALT];
        assign push[p]    = dat_wr[p] & ~full[p];
        assign pop[p]     = load & (gnt == PW'(p));

        assign io_rdata[32*p +: 32] = wa[IO_UART_STAT]
            ? {21'b0, ovf[p], full[p], 1'b0, 8'(count[p])}
            : '0;

        io_txfifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk    (clk),
            .resetn (resetn),
            .push   (push[p]),
            .din    (io_wdata[32*p +: 8]),
            .pop    (pop[p]),
            .dout   (dout[p]),
            .count  (count[p]),
            .full   (full[p]),
            .empty  (empty[p])
        );
    end

    // Search starts one past the last grant, so the previous winner is tried last.
    always_comb begin
        int unsigned idx;
        logic [PW-1:0] idx_p;
        idx    = 0;
        idx_p  = '0;
        gnt    = rr;
        any_ne = 1'b0;
        for (int unsigned i = 1; i <= NPORTS; i++) begin
            idx   = (int'(rr) + i) % NPORTS;
            idx_p = PW'(idx);
            if (!any_ne && !empty[idx_p]) begin
                gnt    = idx_p;
                any_ne = 1'b1;
            end
        end
        load = any_ne & (~uart_valid | uart_ready);
    end

    // A write to a full FIFO beats a same-cycle status-write clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~stat_wr) | (dat_wr & full);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_data  <= '0;
            uart_valid <= 1'b0;
            rr         <= PW'(NPORTS - 1);
        end else if (load) begin
            uart_data  <= dout[gnt];
            uart_valid <= 1'b1;
            rr         <= gnt;
        end else if (uart_valid && uart_ready) begin
            uart_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            halt_pend <= 1'b0;
            halt      <= 1'b0;
        end else begin
            if (|halt_wr) halt_pend <= 1'b1;
            if (halt_pend && (&empty) && !uart_valid) halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_uart_arbiter.sv
// Directed bench for io_uart_arbiter (NPORTS=2, DEPTH=16): arbitration order,
// backpressure, overflow/status, halt drain and asynchronous reset.
module tb_io_uart_arbiter;

    localparam int unsigned NPORTS = 2;
    localparam int unsigned DEPTH  = 16;

    localparam logic [31:0] A_DAT  = 32'h08;
    localparam logic [31:0] A_STAT = 32'h10;
    localparam logic [31:0] A_HALT = 32'h20;

    logic                 clk;
    logic                 resetn;
    logic [NPORTS-1:0]    io_wr;
    logic [NPORTS*32-1:0] io_addr;
    logic [NPORTS*32-1:0] io_wdata;
    logic [NPORTS*32-1:0] io_rdata;
    logic [7:0]           uart_data;
    logic                 uart_valid;
    logic                 uart_ready;
    logic [NPORTS-1:0]    ovf;
    logic                 halt;

    int unsigned passed;
    int unsigned failed;
    int unsigned total;

    io_uart_arbiter #(
        .NPORTS(NPORTS),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .io_wr      (io_wr),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .uart_ready (uart_ready),
        .ovf        (ovf),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the write applied.
    task automatic io_cycle(input logic [1:0] wr, input logic [31:0] a0, input logic [31:0] d0,
                            input logic [31:0] a1, input logic [31:0] d1);
        io_wr    = wr;
        io_addr  = {a1, a0};
        io_wdata = {d1, d0};
        @(negedge clk);
        io_wr = '0;
    endtask

    task automatic status_addr();
        io_addr = {A_STAT, A_STAT};
        #1;
    endtask

    initial begin
        logic [7:0] fair_seq [6];
        passed = 0;
        failed = 0;
        total  = 0;
        fair_seq[0] = 8'h41; fair_seq[1] = 8'h42; fair_seq[2] = 8'h41;
        fair_seq[3] = 8'h42; fair_seq[4] = 8'h41; fair_seq[5] = 8'h41;

        resetn     = 1'b0;
        io_wr      = '0;
        io_addr    = '0;
        io_wdata   = '0;
        uart_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        status_addr();
        chk("rst_valid", 32'(uart_valid), 32'h0);
        chk("rst_data", 32'(uart_data), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_stat_p0", io_rdata[31:0], 32'h0);
        io_addr = {A_DAT, A_DAT};
        #1;
        chk("rd_other_addr_zero", io_rdata[31:0], 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Simultaneous write, ready high
        uart_ready = 1'b1;
        io_cycle(2'b11, A_DAT, 32'h41, A_DAT, 32'h42);
        chk("sim_valid_lat0", 32'(uart_valid), 32'h0);
        status_addr();
        chk("sim_cnt_p0", io_rdata[31:0], 32'h1);
        chk("sim_cnt_p1", io_rdata[63:32], 32'h1);
        @(negedge clk);
        chk("sim_first", 32'({uart_valid, uart_data}), 32'h141);
        @(negedge clk);
        chk("sim_second", 32'({uart_valid, uart_data}), 32'h142);
        @(negedge clk);
        chk("sim_idle", 32'(uart_valid), 32'h0);
        chk("sim_ovf", 32'(ovf), 32'h0);

        // Fairness: AAAA on port0, BB on port1 while stalled
        uart_ready = 1'b0;
        io_cycle(2'b11, A_DAT, 32'h41, A_DAT, 32'h42);
        io_cycle(2'b11, A_DAT, 32'h41, A_DAT, 32'h42);
        io_cycle(2'b01, A_DAT, 32'h41, 32'h0, 32'h0);
        io_cycle(2'b01, A_DAT, 32'h41, 32'h0, 32'h0);
        status_addr();
        chk("fair_cnt_p0", io_rdata[31:0], 32'h3);
        chk("fair_cnt_p1", io_rdata[63:32], 32'h2);
        chk("fair_0", 32'({uart_valid, uart_data}), {23'h0, 1'b1, fair_seq[0]});
        uart_ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("fair_%0d", k), 32'({uart_valid, uart_data}), {23'h0, 1'b1, fair_seq[k]});
        end
        @(negedge clk);
        chk("fair_idle", 32'(uart_valid), 32'h0);

        // Backpressure
        uart_ready = 1'b0;
        io_cycle(2'b01, A_DAT, 32'h5A, 32'h0, 32'h0);
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("bp_hold_%0d", k), 32'({uart_valid, uart_data}), 32'h15A);
            @(negedge clk);
        end
        status_addr();
        chk("bp_cnt_p0", io_rdata[31:0], 32'h0);
        uart_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(uart_valid), 32'h0);

        // Overflow: output register occupied by port0, port1 writes DEPTH+1 bytes
        uart_ready = 1'b0;
        io_cycle(2'b01, A_DAT, 32'h77, 32'h0, 32'h0);
        @(negedge clk);
        for (int i = 0; i <= DEPTH; i++)
            io_cycle(2'b10, 32'h0, 32'h0, A_DAT, 32'h60 + 32'(i));
        chk("ovf_flag", 32'(ovf), 32'h2);
        status_addr();
        chk("ovf_stat_p1", io_rdata[63:32], 32'h0000_0610);
        chk("ovf_stat_p0", io_rdata[31:0], 32'h0);
        io_cycle(2'b10, 32'h0, 32'h0, A_STAT, 32'h0);
        chk("ovf_clear", 32'(ovf), 32'h0);
        status_addr();
        chk("ovf_stat_cleared", io_rdata[63:32], 32'h0000_0210);
        io_cycle(2'b10, 32'h0, 32'h0, A_DAT | A_STAT, 32'h99);
        chk("ovf_set_beats_clear", 32'(ovf), 32'h2);
        io_cycle(2'b10, 32'h0, 32'h0, A_STAT, 32'h0);
        chk("ovf_clear2", 32'(ovf), 32'h0);
        chk("ovf_drain_head", 32'({uart_valid, uart_data}), 32'h177);
        uart_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk($sformatf("ovf_drain_%0d", i), 32'({uart_valid, uart_data}), 32'h160 + 32'(i));
        end
        @(negedge clk);
        chk("ovf_drain_end", 32'(uart_valid), 32'h0);

        // Halt drain
        uart_ready = 1'b0;
        io_cycle(2'b01, A_DAT, 32'h31, 32'h0, 32'h0);
        io_cycle(2'b01, A_DAT, 32'h32, 32'h0, 32'h0);
        io_cycle(2'b01, A_DAT, 32'h33, 32'h0, 32'h0);
        io_cycle(2'b01, A_HALT, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("halt_wait", 32'(halt), 32'h0);
        chk("halt_b0", 32'({uart_valid, uart_data}), 32'h131);
        uart_ready = 1'b1;
        @(negedge clk);
        chk("halt_b1", 32'({halt, uart_valid, uart_data}), 32'h132);
        @(negedge clk);
        chk("halt_b2", 32'({halt, uart_valid, uart_data}), 32'h133);
        @(negedge clk);
        chk("halt_valid_drop", 32'({halt, uart_valid}), 32'h0);
        @(negedge clk);
        chk("halt_set", 32'(halt), 32'h1);
        @(negedge clk);
        chk("halt_hold", 32'(halt), 32'h1);

        // Asynchronous reset mid-stream, last grant was port0
        uart_ready = 1'b0;
        io_cycle(2'b01, A_DAT, 32'h91, 32'h0, 32'h0);
        io_cycle(2'b01, A_DAT, 32'h92, 32'h0, 32'h0);
        chk("ar_pre", 32'({uart_valid, uart_data}), 32'h191);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_valid", 32'(uart_valid), 32'h0);
        chk("ar_halt", 32'(halt), 32'h0);
        status_addr();
        chk("ar_cnt_p0", io_rdata[31:0], 32'h0);
        chk("ar_cnt_p1", io_rdata[63:32], 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        uart_ready = 1'b1;
        io_cycle(2'b11, A_DAT, 32'hA0, A_DAT, 32'hB0);
        chk("ar_lat", 32'(uart_valid), 32'h0);
        @(negedge clk);
        chk("ar_first_p0", 32'({uart_valid, uart_data}), 32'h1A0);
        @(negedge clk);
        chk("ar_second_p1", 32'({uart_valid, uart_data}), 32'h1B0);
        @(negedge clk);
        chk("ar_end", 32'({halt, uart_valid}), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
